inst_fetch_reg: RTL and testbench

Fetch-stage register that sits directly downstream of the program counter and instruction ROM. It feeds the decoder. Each cycle it captures the ROM word addressed by the current program counter, together with that PC value. It squashes the fall-through word on a taken branch, detects the halt opcode and raises Done, and counts fetched instructions. Its Start semantics match the program counter's: Start high means the processor is held idle.

---
 rtl/inst_fetch_reg_if.sv | 27 ++
 rtl/inst_fetch_reg.sv | 99 +++++++++
 tb/tb_inst_fetch_reg.sv | 133 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_reg_if.sv
// Fetch-stage bus: PC/ROM side inputs toward the fetch register and the
// registered instruction outputs toward the decoder.
interface inst_fetch_reg_if #(
  parameter int unsigned A  = 10,
  parameter int unsigned W  = 9,
  parameter int unsigned CW = 16
);
  logic          start;
  logic [A-1:0]  prog_ctr;
  logic [W-1:0]  inst_in;
  logic          branch_taken;
  logic [W-1:0]  inst_out;
  logic [A-1:0]  inst_pc;
  logic          inst_valid;
  logic          done;
  logic [CW-1:0] inst_count;

  modport master (
    output start, prog_ctr, inst_in, branch_taken,
    input  inst_out, inst_pc, inst_valid, done, inst_count
  );

  modport slave (
    input  start, prog_ctr, inst_in, branch_taken,
    output inst_out, inst_pc, inst_valid, done, inst_count
  );
endinterface

// File: rtl/inst_fetch_reg.sv
// Fetch-stage register: captures the ROM word and its PC each cycle, squashes
// the fall-through word on a taken branch, detects halt and counts fetches.
module inst_fetch_reg #(
  parameter int unsigned   A       = 10,
  parameter int unsigned   W       = 9,
  parameter logic [W-1:0]  HALT_OP = W'(9'h1FF),
  parameter int unsigned   CW      = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  inst_fetch_reg_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e        r_state, w_state_d;
  logic [W-1:0]  r_inst_out, w_inst_out_d;
  logic [A-1:0]  r_inst_pc, w_inst_pc_d;
  logic          r_valid, w_valid_d;
  logic          r_done, w_done_d;
  logic [CW-1:0] r_count, w_count_d;
  logic [CW-1:0] w_count_inc;

  // Saturating increment: all-ones sticks rather than wrapping to zero.
  assign w_count_inc = (r_count == {CW{1'b1}}) ? r_count : r_count + 1'b1;

  always_comb begin
    w_state_d    = r_state;
    w_inst_out_d = r_inst_out;
    w_inst_pc_d  = r_inst_pc;
    w_valid_d    = 1'b0;
    w_done_d     = r_done;
    w_count_d    = r_count;

    unique case (r_state)
      StIdle: begin
        if (!bus.start) begin
          w_state_d    = StRun;
          w_inst_out_d = bus.inst_in;
          w_inst_pc_d  = bus.prog_ctr;
          w_valid_d    = 1'b1;
          w_count_d    = {{(CW-1){1'b0}}, 1'b1};
        end
      end
      StRun: begin
        if (bus.start) begin
          w_state_d = StIdle;
        end else if (r_valid && (r_inst_out == HALT_OP)) begin
          w_state_d = StHalt;
          w_done_d  = 1'b1;
        end else if (bus.branch_taken) begin
          // Fall-through word is loaded but marked invalid and not counted.
          w_inst_out_d = bus.inst_in;
          w_inst_pc_d  = bus.prog_ctr;
        end else begin
          w_inst_out_d = bus.inst_in;
          w_inst_pc_d  = bus.prog_ctr;
          w_valid_d    = 1'b1;
          w_count_d    = w_count_inc;
        end
      end
      StHalt: begin
        if (bus.start) begin
          w_state_d = StIdle;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_inst_out <= '0;
      r_inst_pc  <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_inst_out <= w_inst_out_d;
      r_inst_pc  <= w_inst_pc_d;
      r_valid    <= w_valid_d;
      r_done     <= w_done_d;
      r_count    <= w_count_d;
    end
  end

  assign bus.inst_out   = r_inst_out;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_valid = r_valid;
  assign bus.done       = r_done;
  assign bus.inst_count = r_count;

endmodule

// File: tb/tb_inst_fetch_reg.sv
// Directed bench for inst_fetch_reg: fetch, branch bubble, halt, priorities,
// async reset and counter saturation (second instance with a 4-bit counter).
module tb_inst_fetch_reg;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  inst_fetch_reg_if #(.A(10), .W(9), .CW(16)) bus  ();
  inst_fetch_reg_if #(.A(10), .W(9), .CW(4))  bus4 ();

  inst_fetch_reg #(.A(10), .W(9), .HALT_OP(9'h1FF), .CW(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  inst_fetch_reg #(.A(10), .W(9), .HALT_OP(9'h1FF), .CW(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [9:0] pc, input logic [8:0] inst,
                       input logic br);
    bus.start        = st;
    bus.prog_ctr     = pc;
    bus.inst_in      = inst;
    bus.branch_taken = br;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] inst, input logic [9:0] pc,
                            input logic vld, input logic dn, input logic [15:0] cnt);
    check({tag, ".inst"},  32'(bus.inst_out),   32'(inst));
    check({tag, ".pc"},    32'(bus.inst_pc),    32'(pc));
    check({tag, ".valid"}, 32'(bus.inst_valid), 32'(vld));
    check({tag, ".done"},  32'(bus.done),       32'(dn));
    check({tag, ".count"}, 32'(bus.inst_count), 32'(cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    drive(1'b1, 10'd0, 9'h000, 1'b0);
    bus4.start        = 1'b1;
    bus4.prog_ctr     = '0;
    bus4.inst_in      = '0;
    bus4.branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_out("por", 9'h000, 10'd0, 1'b0, 1'b0, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("idle", 9'h000, 10'd0, 1'b0, 1'b0, 16'd0);

    // Straight-line fetch
    drive(1'b0, 10'd0, 9'h010, 1'b0); tick(); expect_out("f0", 9'h010, 10'd0, 1'b1, 1'b0, 16'd1);
    drive(1'b0, 10'd1, 9'h011, 1'b0); tick(); expect_out("f1", 9'h011, 10'd1, 1'b1, 1'b0, 16'd2);
    drive(1'b0, 10'd2, 9'h012, 1'b0); tick(); expect_out("f2", 9'h012, 10'd2, 1'b1, 1'b0, 16'd3);

    // Taken branch at PC 3 to target 40
    drive(1'b0, 10'd3, 9'h013, 1'b1);  tick(); expect_out("br", 9'h013, 10'd3, 1'b0, 1'b0, 16'd3);
    drive(1'b0, 10'd40, 9'h055, 1'b0); tick(); expect_out("tgt", 9'h055, 10'd40, 1'b1, 1'b0, 16'd4);
    drive(1'b0, 10'd41, 9'h056, 1'b0); tick(); expect_out("f41", 9'h056, 10'd41, 1'b1, 1'b0, 16'd5);

    // Asynchronous reset mid-run, no clock edge
    #2 rst_n = 1'b0;
    #1;
    expect_out("arst", 9'h000, 10'd0, 1'b0, 1'b0, 16'd0);
    drive(1'b1, 10'd0, 9'h000, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("arst_idle", 9'h000, 10'd0, 1'b0, 1'b0, 16'd0);

    // Halt at PC 5
    drive(1'b0, 10'd4, 9'h004, 1'b0); tick(); expect_out("h4", 9'h004, 10'd4, 1'b1, 1'b0, 16'd1);
    drive(1'b0, 10'd5, 9'h1FF, 1'b0); tick(); expect_out("h5", 9'h1FF, 10'd5, 1'b1, 1'b0, 16'd2);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 10'(6 + i), 9'(i * 7 + 3), 1'(i % 3 == 0));
      tick();
      expect_out($sformatf("hold%0d", i), 9'h1FF, 10'd5, 1'b0, 1'b1, 16'd2);
    end
    drive(1'b1, 10'd0, 9'h000, 1'b0); tick(); expect_out("unhalt", 9'h1FF, 10'd5, 1'b0, 1'b0, 16'd2);
    tick(); expect_out("unhalt_idle", 9'h1FF, 10'd5, 1'b0, 1'b0, 16'd2);

    // Halt word valid together with BranchTaken: halt wins
    drive(1'b0, 10'd5, 9'h1FF, 1'b0); tick(); expect_out("hb0", 9'h1FF, 10'd5, 1'b1, 1'b0, 16'd1);
    drive(1'b0, 10'd6, 9'h066, 1'b1); tick(); expect_out("hb1", 9'h1FF, 10'd5, 1'b0, 1'b1, 16'd1);
    drive(1'b1, 10'd0, 9'h000, 1'b0); tick(); expect_out("hb2", 9'h1FF, 10'd5, 1'b0, 1'b0, 16'd1);

    // Start with BranchTaken in RUN: idle wins, data holds
    drive(1'b0, 10'd7, 9'h077, 1'b0); tick(); expect_out("sb0", 9'h077, 10'd7, 1'b1, 1'b0, 16'd1);
    drive(1'b1, 10'd8, 9'h088, 1'b1); tick(); expect_out("sb1", 9'h077, 10'd7, 1'b0, 1'b0, 16'd1);
    drive(1'b1, 10'd9, 9'h099, 1'b0); tick(); expect_out("sb2", 9'h077, 10'd7, 1'b0, 1'b0, 16'd1);
    drive(1'b0, 10'd9, 9'h099, 1'b0); tick(); expect_out("sb3", 9'h099, 10'd9, 1'b1, 1'b0, 16'd1);
    drive(1'b1, 10'd0, 9'h000, 1'b0);

    // Saturation on the 4-bit counter instance
    for (int i = 0; i < 20; i++) begin
      bus4.start    = 1'b0;
      bus4.prog_ctr = 10'(i);
      bus4.inst_in  = 9'(i + 1);
      tick();
      check($sformatf("sat%0d", i), 32'(bus4.inst_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    bus4.start = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
